// File: rtl/trap_ctrl_if.sv
// ============================================================================
// Module      : trap_csr_if
// Description : CSR trap write/read port between trap_ctrl and the CSR
//               register file.
//               trap_csr_we_o    - write enable
//               trap_csr_addr_o  - 12-bit CSR address (write and read)
//               trap_csr_wdata_o - write data
//               trap_csr_rdata_i - combinational read of trap_csr_addr_o
//               master modport : trap_ctrl side
//               slave  modport : CSR register file side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trap_csr_if;
  logic        trap_csr_we_o;
  logic [11:0] trap_csr_addr_o;
  logic [31:0] trap_csr_wdata_o;
  logic [31:0] trap_csr_rdata_i;

  modport master (
    output trap_csr_we_o,
    output trap_csr_addr_o,
    output trap_csr_wdata_o,
    input  trap_csr_rdata_i
  );

  modport slave (
    input  trap_csr_we_o,
    input  trap_csr_addr_o,
    input  trap_csr_wdata_o,
    output trap_csr_rdata_i
  );
endinterface

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode trap sequencer. Accepts interrupts, exceptions
//               and mret from the idex stage, walks the CSR trap port through
//               mepc/mcause/(mtval)/mstatus writes and then redirects the PC
//               to mtvec (direct or vectored) or back to mepc for mret. The
//               pipeline is held for the whole sequence.
// Ports       : clk, rst (async, active-high)
//               inst_valid_i, inst_pc_i, inst_i      - idex instruction
//               ecall_i/ebreak_i/illegal_i/mret_i    - decoded flags
//               ex/soft/tcmp_trap_valid_i            - masked irq requests
//               mstatus_mie_i                        - global irq enable
//               csr (trap_csr_if.master)             - CSR trap port
//               hold_o, jump_o, jump_addr_o          - pipeline control
// Config      : TRAP_MTVAL_EN - when defined, the W_TVAL state exists and
//               mtval is written on every trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_ctrl #(
  parameter int TRAP_IDLE_W = 3
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        inst_valid_i,
  input  wire logic [31:0] inst_pc_i,
  input  wire logic [31:0] inst_i,
  input  wire logic        ecall_i,
  input  wire logic        ebreak_i,
  input  wire logic        illegal_i,
  input  wire logic        mret_i,
  input  wire logic        ex_trap_valid_i,
  input  wire logic        soft_trap_valid_i,
  input  wire logic        tcmp_trap_valid_i,
  input  wire logic        mstatus_mie_i,
  trap_csr_if.master       csr,
  output logic             hold_o,
  output logic             jump_o,
  output logic [31:0]      jump_addr_o
);

  localparam logic [11:0] c_MSTATUS = 12'h300;
  localparam logic [11:0] c_MTVEC   = 12'h305;
  localparam logic [11:0] c_MEPC    = 12'h341;
  localparam logic [11:0] c_MCAUSE  = 12'h342;
`ifdef TRAP_MTVAL_EN
  localparam logic [11:0] c_MTVAL   = 12'h343;
`endif

  typedef enum logic [TRAP_IDLE_W-1:0] {
    IDLE    = TRAP_IDLE_W'(0),
    W_EPC   = TRAP_IDLE_W'(1),
    W_CAUSE = TRAP_IDLE_W'(2),
`ifdef TRAP_MTVAL_EN
    W_TVAL  = TRAP_IDLE_W'(3),
`endif
    W_STAT  = TRAP_IDLE_W'(4),
    JUMP    = TRAP_IDLE_W'(5),
    M_STAT  = TRAP_IDLE_W'(6),
    M_JUMP  = TRAP_IDLE_W'(7)
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_cause;
  logic [31:0] r_pc;

  logic        w_irq;
  logic        w_exc;
  logic        w_accept_trap;
  logic        w_accept_mret;
  logic        w_accept;
  logic [31:0] w_cause;

  logic        w_we;
  logic [11:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_jump;
  logic [31:0] w_jump_addr;
  logic [31:0] w_base;
  logic [31:0] w_vec_off;
  logic        w_unused;

  // Acceptance: only in IDLE, only with a valid idex instruction. An
  // interrupt pre-empts any exception or mret on the same instruction.
  // Gating with rst keeps hold_o low while reset is applied.
  assign w_irq         = mstatus_mie_i &
                         (ex_trap_valid_i | soft_trap_valid_i | tcmp_trap_valid_i);
  assign w_exc         = illegal_i | ebreak_i | ecall_i;
  assign w_accept_trap = ~rst & (r_state == IDLE) & inst_valid_i & (w_irq | w_exc);
  assign w_accept_mret = ~rst & (r_state == IDLE) & inst_valid_i &
                         ~w_irq & ~w_exc & mret_i;
  assign w_accept      = w_accept_trap | w_accept_mret;

  always_comb begin
    w_cause = 32'h0;
    if (w_irq) begin
      if (ex_trap_valid_i)        w_cause = 32'h8000_000B;
      else if (soft_trap_valid_i) w_cause = 32'h8000_0003;
      else                        w_cause = 32'h8000_0007;
    end else if (illegal_i) begin
      w_cause = 32'h0000_0002;
    end else if (ebreak_i) begin
      w_cause = 32'h0000_0003;
    end else if (ecall_i) begin
      w_cause = 32'h0000_000B;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cause <= 32'h0;
      r_pc    <= 32'h0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cause <= w_cause;
        r_pc    <= inst_pc_i;
      end
    end
  end

`ifdef TRAP_MTVAL_EN
  logic [31:0] r_tval;
  logic [31:0] w_tval;

  always_comb begin
    w_tval = 32'h0;
    if (!w_irq) begin
      if (illegal_i)     w_tval = inst_i;
      else if (ebreak_i) w_tval = inst_pc_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tval <= 32'h0;
    end else if (w_accept) begin
      r_tval <= w_tval;
    end
  end

  assign w_unused = r_cause[30];
`else
  // Without mtval support the instruction word has no consumer.
  assign w_unused = r_cause[30] ^ (^inst_i);
`endif

  // mtvec base and vectored offset (4 * interrupt cause code).
  assign w_base    = {csr.trap_csr_rdata_i[31:2], 2'b00};
  assign w_vec_off = {r_cause[29:0], 2'b00};

  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    w_addr       = 12'h0;
    w_wdata      = 32'h0;
    w_jump       = 1'b0;
    w_jump_addr  = 32'h0;
    case (r_state)
      IDLE: begin
        if (w_accept_trap)      w_next_state = W_EPC;
        else if (w_accept_mret) w_next_state = M_STAT;
      end
      W_EPC: begin
        w_we         = 1'b1;
        w_addr       = c_MEPC;
        w_wdata      = r_pc;
        w_next_state = W_CAUSE;
      end
      W_CAUSE: begin
        w_we    = 1'b1;
        w_addr  = c_MCAUSE;
        w_wdata = r_cause;
`ifdef TRAP_MTVAL_EN
        w_next_state = W_TVAL;
`else
        w_next_state = W_STAT;
`endif
      end
`ifdef TRAP_MTVAL_EN
      W_TVAL: begin
        w_we         = 1'b1;
        w_addr       = c_MTVAL;
        w_wdata      = r_tval;
        w_next_state = W_STAT;
      end
`endif
      W_STAT: begin
        // Read-modify-write in one cycle: MPIE <= MIE, MIE <= 0.
        w_we         = 1'b1;
        w_addr       = c_MSTATUS;
        w_wdata      = {24'h0, csr.trap_csr_rdata_i[3], 7'h0};
        w_next_state = JUMP;
      end
      JUMP: begin
        w_addr = c_MTVEC;
        w_jump = 1'b1;
        if (csr.trap_csr_rdata_i[1:0] == 2'b01 && r_cause[31])
          w_jump_addr = w_base + w_vec_off;
        else
          w_jump_addr = w_base;
        w_next_state = IDLE;
      end
      M_STAT: begin
        // MIE <= MPIE, MPIE <= 1.
        w_we         = 1'b1;
        w_addr       = c_MSTATUS;
        w_wdata      = {24'h0, 1'b1, 3'b000, csr.trap_csr_rdata_i[7], 3'b000};
        w_next_state = M_JUMP;
      end
      M_JUMP: begin
        w_addr       = c_MEPC;
        w_jump       = 1'b1;
        w_jump_addr  = {csr.trap_csr_rdata_i[31:2], 2'b00};
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign csr.trap_csr_we_o    = w_we;
  assign csr.trap_csr_addr_o  = w_addr;
  assign csr.trap_csr_wdata_o = w_wdata;
  assign jump_o               = w_jump;
  assign jump_addr_o          = w_jump_addr;
  assign hold_o               = (r_state != IDLE) | w_accept;

endmodule

`default_nettype wire

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer placed directly downstream of the CSR register file. It consumes the masked interrupt requests and the global `MIE` bit from the CSR block, plus exception and `mret` flags from the idex stage. It drives the CSR trap port through a fixed multi-cycle write sequence covering `mepc`, `mcause`, `mtval` and `mstatus`. It then issues a single-cycle redirect to the handler, or back to `mepc` for `mret`, holding the pipeline for the whole sequence.

## Interface
- `TRAP_IDLE_W`, default 3: FSM state register width.
- `clk` in 1: core clock, all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `inst_valid_i` in 1: idex holds a valid instruction this cycle.
- `inst_pc_i` in 32: PC of that instruction.
- `inst_i` in 32: instruction word, used for `mtval`.
- `ecall_i`, `ebreak_i`, `illegal_i`, `mret_i` in 1 each: decoded flags, qualified by `inst_valid_i`.
- `ex_trap_valid_i`, `soft_trap_valid_i`, `tcmp_trap_valid_i` in 1 each: masked requests from the CSR block.
- `mstatus_mie_i` in 1: global interrupt enable.
- `trap_csr_we_o` out 1, `trap_csr_addr_o` out 12, `trap_csr_wdata_o` out 32: CSR trap write port.
- `trap_csr_rdata_i` in 32: combinational CSR read of `trap_csr_addr_o`.
- `hold_o` out 1: stall fetch and idex, and suppress idex CSR writes.
- `jump_o` out 1: one-cycle PC redirect.
- `jump_addr_o` out 32: redirect target.

## Operation
- Trap request: `irq = mstatus_mie_i & (ex|soft|tcmp)`, evaluated in IDLE with `inst_valid_i`.
- Priority: interrupt > exception (`illegal` > `ebreak` > `ecall`) > `mret`.
- Interrupt priority: external > software > timer.
- `mcause` codes:
  - External `0x8000000B`, software `0x80000003`, timer `0x80000007`.
  - Illegal `0x00000002`, ebreak `0x00000003`, ecall `0x0000000B`.
- `mepc` is always `inst_pc_i` (the instruction is squashed for interrupts and for exceptions).
- `mtval`: `inst_i` for illegal, `inst_pc_i` for ebreak, 0 otherwise.
- On acceptance, cause, pc and tval are latched into internal registers. Later inputs are ignored until return to IDLE.
- Trap FSM: IDLE → W_EPC → W_CAUSE → W_TVAL → W_STAT → JUMP → IDLE.
- Each W_ state asserts `we=1` with the matching CSR address (`mepc` 0x341, `mcause` 0x342, `mtval` 0x343, `mstatus` 0x300).
- W_STAT reads `mstatus` via `rdata` in the same cycle and writes it back with `MPIE[7]=rdata[3]`, `MIE[3]=0`, all other bits 0.
- JUMP sets `addr=mtvec` (0x305) with `we=0` and asserts `jump_o`.
  - `jump_addr_o = {rdata[31:2],2'b00}`.
  - If `rdata[1:0]==2'b01` and the cause is an interrupt, the target is `base + 4*cause[30:0]` (vectored mode).
- mret FSM: IDLE → M_STAT → M_JUMP → IDLE.
  - M_STAT writes `mstatus` with `MIE=rdata[7]`, `MPIE=1`.
  - M_JUMP reads `mepc` (0x341) and asserts `jump_o` with `jump_addr_o = {rdata[31:2],2'b00}`.
- `hold_o = (state != IDLE) | accept`, combinational. Upstream stays frozen and idex CSR writes are blocked, so idex write priority in the CSR block never collides with trap writes.
- Outside W_ states: `we=0`, `wdata=0`, `addr=0`.

## Timing
- Reset: state IDLE, latched registers 0, and all outputs 0 (`hold_o`, `jump_o`, `jump_addr_o`, `we`, `addr`, `wdata`).
- Cycle 0 is the acceptance cycle in IDLE, with `hold_o=1` combinationally.
- With `TRAP_MTVAL_EN`: CSR writes occur on cycles 1–4 and `jump_o` on cycle 5.
- Without `TRAP_MTVAL_EN`: writes occur on cycles 1–3 and `jump_o` on cycle 4.
- mret: write on cycle 1, `jump_o` on cycle 2.
- `jump_o` is high for exactly one cycle. `hold_o` drops in the cycle after JUMP/M_JUMP.
- Simultaneous events:
  - An interrupt together with `mret` or an exception takes the interrupt; the instruction is re-fetched after the handler returns.
  - A request arriving in the JUMP cycle is ignored; it is re-evaluated in IDLE on the next cycle against the new instruction.
  - `inst_valid_i=0` blocks all acceptance, including interrupts.
- Reset asserted mid-sequence: return to IDLE immediately, with no further CSR writes and no jump.

## Configuration
- `TRAP_MTVAL_EN` defined: the W_TVAL state exists and `mtval` is written on every trap.
- `TRAP_MTVAL_EN` undefined: W_TVAL is removed (W_CAUSE → W_STAT), `mtval` is never written by this block, and trap latency shrinks by one cycle.

## Test plan
- External interrupt: `MIE=1`, `ex=1`, PC `0x100`, `mtvec=0x200`. Required: writes `mepc=0x100`, `mcause=0x8000000B`, `mtval=0`, `mstatus=0x80`; `jump_o` on cycle 5 with `jump_addr_o=0x200`.
- Illegal instruction: `inst_i=0xFFFFFFFF` at PC `0x40`. Required: `mcause=2`, `mtval=0xFFFFFFFF`, jump to `mtvec` base; `hold_o` high on cycles 0–5.
- Vectored timer interrupt: `mtvec=0x301`, `tcmp=1`. Required: `mcause=0x80000007`, `jump_addr_o=0x31C`.
- mret: `mstatus=0x80`, `mepc=0x104`. Required: `mstatus` write `0x88` on cycle 1; `jump_o` with `0x104` on cycle 2.
- Simultaneous events: `ex`, `soft`, `ecall` and `mret` all high. Required: `mcause=0x8000000B`, `mepc=inst_pc_i`. Separately, `MIE=0` with `ex=1` gives no trap and `hold_o=0`.
- Reset pulse in W_CAUSE. Required: `we=0` from reset onward, no `jump_o`; the FSM is IDLE and accepts a new ecall one cycle after reset deasserts.
